// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - UART 8N1 receiver with input synchroniser and framing-error detection
module serial_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       data_in,
    output logic [7:0] val_out,
    output logic       valid_out,
    output logic       frame_err_out,
    output logic       busy_out
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  val_q, val_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;

    // Synchroniser chain; resets to idle-high so reset never looks like a start bit
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
        end
    end

    assign rx = sync_q[SYNC_STAGES-1];

    // State, counters, shift register and registered output strobes
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            val_q   <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            val_q   <= val_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic: mid-bit start validation, centre sampling of data and stop
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        bit_d   = bit_q;
        shift_d = shift_q;
        val_d   = val_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = rx ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx) begin
                        val_d   = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                // A held-low line (break) must not be re-read as fresh frames
                cnt_d = '0;
                if (rx) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign val_out       = val_q;
    assign valid_out     = valid_q;
    assign frame_err_out = ferr_q;
    assign busy_out      = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - scoreboard testbench for serial_rx at 16 clocks per bit
module tb_serial_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       din;
    logic [7:0] val;
    logic       valid;
    logic       ferr;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];
    int         vtime[$];
    int         n_valid = 0;
    int         n_ferr  = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ferr  = 1'b0;

    serial_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .data_in      (din),
        .val_out      (val),
        .valid_out    (valid),
        .frame_err_out(ferr),
        .busy_out     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on each valid pulse, checks pulse shape
    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            vtime.push_back(cyc);
            check("valid_width", {31'd0, prev_valid}, 32'd0);
            check("valid_and_ferr", {31'd0, ferr}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {24'd0, val}, 32'hFFFF_FFFF);
            end else begin
                check("rx_byte", {24'd0, val}, {24'd0, exp_q.pop_front()});
            end
        end
        if (ferr) begin
            n_ferr++;
            check("ferr_width", {31'd0, prev_ferr}, 32'd0);
        end
        prev_valid = valid;
        prev_ferr  = ferr;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit, input logic expect_ok);
        if (expect_ok) exp_q.push_back(b);
        din = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            din = b[i];
            tick(CPB);
        end
        din = stop_bit;
        tick(CPB);
    endtask

    task automatic drain(input string name, input int limit);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < limit) begin
            tick(1);
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    int start_cyc;
    int base_valid;
    int busy_cnt;
    int any_out;

    initial begin
        rst = 1'b1;
        din = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state and long idle
        check("reset_val", {24'd0, val}, 32'h00);
        check("reset_busy", {31'd0, busy}, 0);
        any_out = 0;
        for (int i = 0; i < 500; i++) begin
            if (valid || ferr || busy) any_out++;
            tick(1);
        end
        check("idle_quiet", any_out, 0);
        check("idle_val", {24'd0, val}, 32'h00);

        // Separate frames
        start_cyc = cyc;
        send(8'hA5, 1'b1, 1'b1);
        tick(20);
        send(8'h00, 1'b1, 1'b1);
        tick(20);
        send(8'hFF, 1'b1, 1'b1);
        drain("drain_separate", 200);
        tick(20);
        if (vtime.size() >= 1) begin
            check("first_latency_ok", {31'd0, (vtime[0] - start_cyc >= 154) && (vtime[0] - start_cyc <= 156)}, 1);
            if (!((vtime[0] - start_cyc >= 154) && (vtime[0] - start_cyc <= 156)))
                $display("  latency measured %0d cycles, want 155+-1", vtime[0] - start_cyc);
        end else begin
            check("first_latency_seen", 0, 1);
        end

        // Back-to-back frames
        base_valid = n_valid;
        send(8'h3C, 1'b1, 1'b1);
        send(8'hC3, 1'b1, 1'b1);
        drain("drain_b2b", 200);
        tick(20);
        check("b2b_count", n_valid - base_valid, 2);
        if (vtime.size() >= base_valid + 2)
            check("b2b_spacing", vtime[base_valid+1] - vtime[base_valid], 160);

        // Start glitch
        base_valid = n_valid;
        din = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 5) din = 1'b1;
            tick(1);
            if (busy) busy_cnt++;
        end
        check("glitch_busy_short", {31'd0, (busy_cnt <= 13) && (busy_cnt > 0)}, 1);
        check("glitch_busy_end", {31'd0, busy}, 0);
        check("glitch_no_valid", n_valid - base_valid, 0);
        check("glitch_no_ferr", n_ferr, 0);

        // Framing error followed by break, then a good frame
        send(8'h55, 1'b0, 1'b0);
        tick(100);
        check("ferr_count", n_ferr, 1);
        check("break_busy", {31'd0, busy}, 1);
        check("ferr_val_hold", {24'd0, val}, 32'hC3);
        din = 1'b1;
        tick(20);
        check("break_released", {31'd0, busy}, 0);
        send(8'h12, 1'b1, 1'b1);
        drain("drain_after_ferr", 200);
        tick(20);

        // Reset mid-frame at data bit 4 of 0xF0
        base_valid = n_valid;
        din = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            din = 1'b0;
            tick(CPB);
        end
        din = 1'b1;
        tick(8);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_val", {24'd0, val}, 32'h00);
        check("midrst_busy", {31'd0, busy}, 0);
        tick(40);
        check("midrst_no_strobe", n_valid - base_valid, 0);
        send(8'h81, 1'b1, 1'b1);
        drain("drain_after_rst", 200);
        tick(40);

        check("total_valid", n_valid, 7);
        check("total_ferr", n_ferr, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_rx.md
Name: serial_rx

Overview:
- UART receiver, 8N1, LSB first, line idle high. The receive-side counterpart of serial_tx.
- Takes the asynchronous serial input (e.g. a UART TX pin from the host), synchronises it, and validates the start bit at mid-bit.
- Samples each data bit at its centre and presents the received byte with a one-cycle valid strobe.
- Flags framing errors. Sits beside serial_tx in top-level designs, driving LEDs or downstream logic.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200 baud). Must be >= 8.
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser. Must be >= 2.

Ports:
- clk_in  input  1  system clock (100 MHz)
- rst_in  input  1  synchronous, active-high reset
- data_in  input  1  asynchronous serial line, idle high
- val_out  output  8  last correctly received byte
- valid_out  output  1  one-cycle pulse: val_out just updated
- frame_err_out  output  1  one-cycle pulse: stop bit sampled low
- busy_out  output  1  high while a frame is in progress (any state but IDLE)

Behaviour:
- Reset values:
  - val_out = 8'h00; valid_out = 0; frame_err_out = 0; busy_out = 0.
  - Synchroniser flops = 1 (idle line), so reset does not fake a start bit.
  - State = IDLE; bit counter = 0; cycle counter = 0.
- Synchroniser: data_in passes through SYNC_STAGES flops. All logic below uses the synchronised bit (rx).
- Cycle counter: counts 0..CLKS_PER_BIT-1. Width is $clog2(CLKS_PER_BIT). Cleared on every state entry.
- State machine:
  - IDLE: when rx == 0, go to START and clear the counter.
  - START: at count == CLKS_PER_BIT/2 - 1 (integer divide), sample rx.
    - rx == 1: glitch; return to IDLE and assert nothing.
    - rx == 0: go to DATA with bit index 0 and counter 0.
  - DATA: at count == CLKS_PER_BIT - 1, shift rx into shift_reg[7] (right shift, so LSB lands in bit 0 after 8 shifts) and increment the bit index.
    - After the 8th sample, go to STOP.
  - STOP: at count == CLKS_PER_BIT - 1, sample rx.
    - rx == 1: val_out <= shift_reg, valid_out = 1 for exactly one cycle, go to IDLE.
    - rx == 0: frame_err_out = 1 for one cycle, val_out unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: remain until rx == 1, then go to IDLE. This prevents a break condition (line held low) from being re-read as repeated frames.
- Latency: valid_out rises SYNC_STAGES + 1 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (±1) after data_in falls for the start bit, i.e. mid stop bit.
- Back-to-back frames: IDLE is re-entered at mid stop bit, so a start edge arriving immediately after the stop bit is caught with no frame lost.
- valid_out and frame_err_out are never high in the same cycle.
- val_out holds its value between frames. No consumer handshake: a byte not consumed before the next valid_out is overwritten.
- rst_in asserted mid-frame: next cycle all outputs, counters and state return to reset values. The partial byte is discarded and no strobe is issued.
- Counter/bit-index wrap: both counters clear on every state transition and never free-run past their terminal value.

Test Plan:
All tests use CLKS_PER_BIT=16. The bench drives frames at exactly 16 clocks per bit.

- Reset, then line idle for 500 cycles -> valid_out, frame_err_out and busy_out stay 0; val_out == 8'h00.
- Send 8'hA5, 8'h00, 8'hFF as separate frames -> three valid_out pulses, each exactly 1 cycle wide, with val_out = A5, 00, FF in turn. First pulse arrives 3+8+144 (±1) cycles after the start edge.
- Send 8'h3C, 8'hC3 back-to-back with no idle gap -> two valid_out pulses exactly 160 cycles apart; val_out = 3C then C3.
- Pull data_in low for 5 cycles, then high -> no valid_out or frame_err_out; busy_out high for ≤ 13 cycles, then 0.
- Send a frame of data 8'h55 with the stop bit low, holding the line low for 100 extra cycles, then send 8'h12 -> one frame_err_out pulse and val_out unchanged; busy_out stays high until the line returns high; then valid_out with val_out = 8'h12.
- Assert rst_in for 1 cycle at data bit 4 of 8'hF0, then send 8'h81 -> no strobe for the aborted frame; val_out == 8'h00 after reset; then valid_out with val_out = 8'h81.
